mem_port_arb: RTL and testbench
===============================

MEM_PORT_ARB -- requirements
Module: mem_port_arb

Interface
REQ-001 Parameter STARVE_MAX, default 4: maximum consecutive data grants while an instruction request waits (range 1..15).
REQ-002 Parameter TIMEOUT, default 16: maximum cycles to wait for M_ACK (range 2..255).
REQ-003 CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 RSTN  input  1  reset, synchronous and active-low, sampled on the rising edge of CLK.
REQ-005 I_REQ  input  1  instruction-fetch request, held high until I_GNT.
REQ-006 I_ADDR  input  30  instruction word address.
REQ-007 I_GNT  output  1  one-cycle grant pulse to the fetch requester.
REQ-008 I_VALID  output  1  one-cycle pulse: I_RDATA is valid.
REQ-009 I_RDATA  output  32  fetched instruction.
REQ-010 D_REQ  input  1  data request, held high until D_GNT.
REQ-011 D_RW  input  1  1 = write, 0 = read.
REQ-012 D_ADDR  input  30  data word address.
REQ-013 D_WDATA  input  32  store data.
REQ-014 D_GNT  output  1  one-cycle grant pulse to the data requester.
REQ-015 D_VALID  output  1  one-cycle completion pulse; D_RDATA is valid on reads.
REQ-016 D_RDATA  output  32  load data.
REQ-017 M_REQ  output  1  memory request, held until M_ACK or timeout.
REQ-018 M_RW  output  1  memory write strobe.
REQ-019 M_ADDR  output  30  memory word address.
REQ-020 M_WDATA  output  32  memory write data.
REQ-021 M_RDATA  input  32  memory read data, valid when M_ACK = 1.
REQ-022 M_ACK  input  1  memory completion.
REQ-023 ERR  output  1  one-cycle pulse on timeout.

Function
REQ-024 All outputs shall be registered.
REQ-025 The FSM shall have three states: IDLE, I_ACC and D_ACC; one transaction is outstanding at most.
REQ-026 In IDLE, the arbiter shall grant data when D_REQ = 1 and either I_REQ = 0 or starve_cnt < STARVE_MAX; otherwise it shall grant instruction when I_REQ = 1.
REQ-027 On a grant edge, the arbiter shall:
  - enter the matching ACC state;
  - pulse the matching GNT for exactly one cycle;
  - set M_REQ = 1;
  - latch M_ADDR, M_RW (forced 0 for fetches) and M_WDATA from the granted requester.
REQ-028 While in ACC, M_ADDR, M_RW and M_WDATA shall stay stable regardless of requester inputs.
REQ-029 starve_cnt (4 bits) behaviour:
  - increments, saturating at 15, on each data grant made while I_REQ = 1;
  - clears on every instruction grant;
  - unchanged otherwise.
REQ-030 When M_ACK = 1 in ACC, the next edge shall:
  - clear M_REQ and M_RW;
  - load M_RDATA into the matching RDATA output;
  - pulse the matching VALID for one cycle;
  - return to IDLE.
REQ-031 Write completion shall pulse D_VALID and leave D_RDATA unchanged.
REQ-032 Each transaction shall spend at least one IDLE cycle between completions, so M_ACK in the grant cycle gives 3 cycles from REQ sample to VALID.
REQ-033 An 8-bit wait counter shall clear on grant and increment each ACC cycle without M_ACK; reaching TIMEOUT-1 without M_ACK, the next edge shall clear M_REQ, pulse ERR, pulse the matching VALID with RDATA = 32'hDEAD_BEEF, and return to IDLE.
REQ-034 M_ACK received in IDLE shall be ignored.
REQ-035 I_REQ or D_REQ dropped after grant shall not abort the transaction.
REQ-036 RDATA outputs shall hold their value between VALID pulses.

Reset
REQ-037 With RSTN = 0 at a rising edge, all of the following shall be cleared on that edge, including mid-transaction: state to IDLE; starve_cnt, wait counter, all GNT/VALID pulses, M_REQ, M_RW, M_ADDR, M_WDATA, I_RDATA, D_RDATA and ERR to 0.
REQ-038 No pending transaction shall resume after reset release; the first grant shall occur no earlier than the first edge with RSTN = 1.

Verification
REQ-039 I_REQ = 1, I_ADDR = 0x10, M_ACK returned the cycle after grant with M_RDATA = 0x1234_5678 -> one I_GNT pulse, M_ADDR = 0x10, M_RW = 0, then I_VALID with I_RDATA = 0x1234_5678.
REQ-040 I_REQ and D_REQ (write, D_ADDR = 0x20, D_WDATA = 0xA5A5_A5A5) asserted together, D_REQ held continuously -> data granted first with M_RW = 1; after 4 data grants the fifth grant is instruction; starve_cnt then reads 0.
REQ-041 D read with M_ACK withheld -> after 16 ACC cycles: ERR pulse, D_VALID with D_RDATA = 0xDEAD_BEEF, M_REQ = 0, state IDLE.
REQ-042 RSTN = 0 asserted during D_ACC -> next edge: M_REQ = 0, no D_VALID, all outputs 0; a late M_ACK is ignored.
REQ-043 M_ACK pulsed while IDLE with no requests -> no VALID, no state change; D_REQ dropped one cycle after D_GNT -> transaction still completes with D_VALID.

Source files
------------

// File: rtl/mem_port_arb.sv
// Two-requester memory port arbiter: instruction fetch vs data access.
// One outstanding transaction, starvation guard, and ack timeout.
module mem_port_arb #(
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        I_REQ,
    input  logic [29:0] I_ADDR,
    output logic        I_GNT,
    output logic        I_VALID,
    output logic [31:0] I_RDATA,
    input  logic        D_REQ,
    input  logic        D_RW,
    input  logic [29:0] D_ADDR,
    input  logic [31:0] D_WDATA,
    output logic        D_GNT,
    output logic        D_VALID,
    output logic [31:0] D_RDATA,
    output logic        M_REQ,
    output logic        M_RW,
    output logic [29:0] M_ADDR,
    output logic [31:0] M_WDATA,
    input  logic [31:0] M_RDATA,
    input  logic        M_ACK,
    output logic        ERR
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        I_ACC = 2'd1,
        D_ACC = 2'd2
    } state_t;

    localparam logic [3:0] SMAX  = 4'(STARVE_MAX);
    localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);
    localparam logic [31:0] BAD  = 32'hDEAD_BEEF;

    state_t     state;
    logic [3:0] starve_cnt;
    logic [7:0] wait_cnt;
    logic       pick_d;
    logic       pick_i;

    // Data wins unless a fetch has already been passed over SMAX times
    always_comb begin
        pick_d = D_REQ && (!I_REQ || (starve_cnt < SMAX));
        pick_i = !pick_d && I_REQ;
    end

    // Arbitration FSM with fully registered outputs
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state      <= IDLE;
            starve_cnt <= '0;
            wait_cnt   <= '0;
            I_GNT      <= 1'b0;
            D_GNT      <= 1'b0;
            I_VALID    <= 1'b0;
            D_VALID    <= 1'b0;
            I_RDATA    <= '0;
            D_RDATA    <= '0;
            M_REQ      <= 1'b0;
            M_RW       <= 1'b0;
            M_ADDR     <= '0;
            M_WDATA    <= '0;
            ERR        <= 1'b0;
        end else begin
            I_GNT   <= 1'b0;
            D_GNT   <= 1'b0;
            I_VALID <= 1'b0;
            D_VALID <= 1'b0;
            ERR     <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pick_d) begin
                        state    <= D_ACC;
                        D_GNT    <= 1'b1;
                        M_REQ    <= 1'b1;
                        M_RW     <= D_RW;
                        M_ADDR   <= D_ADDR;
                        M_WDATA  <= D_WDATA;
                        wait_cnt <= '0;
                        if (I_REQ && (starve_cnt != 4'hF))
                            starve_cnt <= starve_cnt + 4'd1;
                    end else if (pick_i) begin
                        state      <= I_ACC;
                        I_GNT      <= 1'b1;
                        M_REQ      <= 1'b1;
                        M_RW       <= 1'b0;
                        M_ADDR     <= I_ADDR;
                        M_WDATA    <= '0;
                        wait_cnt   <= '0;
                        starve_cnt <= '0;
                    end
                end
                I_ACC, D_ACC: begin
                    if (M_ACK) begin
                        state <= IDLE;
                        M_REQ <= 1'b0;
                        M_RW  <= 1'b0;
                        if (state == I_ACC) begin
                            I_VALID <= 1'b1;
                            I_RDATA <= M_RDATA;
                        end else begin
                            D_VALID <= 1'b1;
                            if (!M_RW)
                                D_RDATA <= M_RDATA;
                        end
                    end else if (wait_cnt == TLAST) begin
                        state <= IDLE;
                        M_REQ <= 1'b0;
                        M_RW  <= 1'b0;
                        ERR   <= 1'b1;
                        if (state == I_ACC) begin
                            I_VALID <= 1'b1;
                            I_RDATA <= BAD;
                        end else begin
                            D_VALID <= 1'b1;
                            D_RDATA <= BAD;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arb.sv
// Self-checking bench for mem_port_arb.
// Expected completions are queued at stimulus time and checked on VALID.
module tb_mem_port_arb;
    logic        CLK = 1'b0;
    logic        RSTN;
    logic        I_REQ;
    logic [29:0] I_ADDR;
    logic        I_GNT;
    logic        I_VALID;
    logic [31:0] I_RDATA;
    logic        D_REQ;
    logic        D_RW;
    logic [29:0] D_ADDR;
    logic [31:0] D_WDATA;
    logic        D_GNT;
    logic        D_VALID;
    logic [31:0] D_RDATA;
    logic        M_REQ;
    logic        M_RW;
    logic [29:0] M_ADDR;
    logic [31:0] M_WDATA;
    logic [31:0] M_RDATA;
    logic        M_ACK;
    logic        ERR;

    typedef struct {
        logic        is_d;
        logic        rw;
        logic        err;
        logic [31:0] rdata;
    } sb_t;

    sb_t         sb[$];
    sb_t         ent;
    int          n_chk  = 0;
    int          n_pass = 0;
    int          mem_lat = 0;
    int          acc_cyc = 0;
    logic        force_ack = 1'b0;
    logic [31:0] exp_d = '0;
    logic [31:0] exp_i = '0;

    mem_port_arb #(.STARVE_MAX(4), .TIMEOUT(16)) dut (
        .CLK(CLK), .RSTN(RSTN),
        .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_GNT(I_GNT),
        .I_VALID(I_VALID), .I_RDATA(I_RDATA),
        .D_REQ(D_REQ), .D_RW(D_RW), .D_ADDR(D_ADDR),
        .D_WDATA(D_WDATA), .D_GNT(D_GNT),
        .D_VALID(D_VALID), .D_RDATA(D_RDATA),
        .M_REQ(M_REQ), .M_RW(M_RW), .M_ADDR(M_ADDR),
        .M_WDATA(M_WDATA), .M_RDATA(M_RDATA),
        .M_ACK(M_ACK), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_data(input logic [29:0] a);
        if (a == 30'h10)
            return 32'h1234_5678;
        return {2'b00, a} ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_gnt();
        for (int i = 0; i < 50; i++) begin
            tick();
            if (I_GNT || D_GNT)
                return;
        end
        check("gnt_wait", 32'd0, 32'd1);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            n++;
            if (I_VALID || D_VALID)
                return;
        end
        check("valid_wait", 32'd0, 32'd1);
    endtask

    // Memory model: acks on the mem_lat-th ACC cycle, or on demand
    always @(negedge CLK) begin
        if (M_REQ)
            acc_cyc = acc_cyc + 1;
        else
            acc_cyc = 0;
        M_ACK = force_ack ||
                (M_REQ && mem_lat != 0 && acc_cyc == mem_lat);
        M_RDATA = mem_data(M_ADDR);
    end

    // Scoreboard monitor: every VALID/ERR must match the queue head
    always @(posedge CLK) begin
        #1;
        if (RSTN && (I_VALID || D_VALID || ERR)) begin
            if (sb.size() == 0) begin
                check("stray_valid",
                      {29'd0, I_VALID, D_VALID, ERR}, 32'd0);
            end else begin
                ent = sb.pop_front();
                check("valid_sel", {30'd0, I_VALID, D_VALID},
                      ent.is_d ? 32'd1 : 32'd2);
                check("err", {31'd0, ERR}, {31'd0, ent.err});
                if (ent.is_d) begin
                    if (!(ent.rw && !ent.err))
                        exp_d = ent.rdata;
                    check("d_rdata", D_RDATA, exp_d);
                end else begin
                    exp_i = ent.rdata;
                    check("i_rdata", I_RDATA, exp_i);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        RSTN = 1'b0;
        I_REQ = 1'b0;
        I_ADDR = '0;
        D_REQ = 1'b0;
        D_RW = 1'b0;
        D_ADDR = '0;
        D_WDATA = '0;
        tick();
        tick();
        check("rst_mreq", {31'd0, M_REQ}, 32'd0);
        check("rst_maddr", {2'b0, M_ADDR}, 32'd0);
        check("rst_rdata", I_RDATA | D_RDATA, 32'd0);
        RSTN = 1'b1;
        tick();

        // Single fetch
        mem_lat = 2;
        I_REQ = 1'b1;
        I_ADDR = 30'h10;
        sb.push_back('{1'b0, 1'b0, 1'b0, 32'h1234_5678});
        wait_gnt();
        check("f_igrant", {31'd0, I_GNT}, 32'd1);
        check("f_maddr", {2'b0, M_ADDR}, 32'h10);
        check("f_mrw", {31'd0, M_RW}, 32'd0);
        check("f_mreq", {31'd0, M_REQ}, 32'd1);
        I_REQ = 1'b0;
        tick();
        check("f_gnt_pulse", {31'd0, I_GNT}, 32'd0);
        wait_valid(n);
        check("f_mreq_clr", {31'd0, M_REQ}, 32'd0);
        check("starve0", {28'd0, dut.starve_cnt}, 32'd0);

        // Starvation guard: four data writes then the fetch
        mem_lat = 1;
        I_REQ = 1'b1;
        I_ADDR = 30'h14;
        D_REQ = 1'b1;
        D_RW = 1'b1;
        D_ADDR = 30'h20;
        D_WDATA = 32'hA5A5_A5A5;
        for (int g = 0; g < 4; g++)
            sb.push_back('{1'b1, 1'b1, 1'b0, 32'h0});
        sb.push_back('{1'b0, 1'b0, 1'b0, mem_data(30'h14)});
        for (int g = 0; g < 5; g++) begin
            wait_gnt();
            check("arb_order", {30'd0, I_GNT, D_GNT},
                  (g == 4) ? 32'd2 : 32'd1);
            if (g < 4) begin
                check("s_mrw", {31'd0, M_RW}, 32'd1);
                check("s_maddr", {2'b0, M_ADDR}, 32'h20);
                check("s_wdata", M_WDATA, 32'hA5A5_A5A5);
                check("s_cnt", {28'd0, dut.starve_cnt}, g + 1);
            end else begin
                check("s_imrw", {31'd0, M_RW}, 32'd0);
                check("s_imaddr", {2'b0, M_ADDR}, 32'h14);
                check("s_clr", {28'd0, dut.starve_cnt}, 32'd0);
                I_REQ = 1'b0;
                D_REQ = 1'b0;
            end
            wait_valid(n);
        end

        // Minimum latency: ack during the grant cycle
        D_RW = 1'b0;
        D_ADDR = 30'h50;
        sb.push_back('{1'b1, 1'b0, 1'b0, mem_data(30'h50)});
        D_REQ = 1'b1;
        tick();
        check("lat_gnt", {31'd0, D_GNT}, 32'd1);
        D_REQ = 1'b0;
        tick();
        check("lat_valid", {31'd0, D_VALID}, 32'd1);
        tick();

        // Ack while idle is ignored
        force_ack = 1'b1;
        tick();
        force_ack = 1'b0;
        tick();
        tick();
        check("idle_ack", {30'd0, I_VALID, D_VALID}, 32'd0);
        check("idle_mreq", {31'd0, M_REQ}, 32'd0);

        // Requester drops after grant; write still completes
        mem_lat = 3;
        D_RW = 1'b1;
        D_ADDR = 30'h44;
        D_WDATA = 32'h0BAD_F00D;
        sb.push_back('{1'b1, 1'b1, 1'b0, 32'h0});
        D_REQ = 1'b1;
        wait_gnt();
        tick();
        D_REQ = 1'b0;
        wait_valid(n);
        check("drop_dvalid", {31'd0, D_VALID}, 32'd1);
        tick();

        // Timeout on a data read, address held stable meanwhile
        mem_lat = 0;
        D_RW = 1'b0;
        D_ADDR = 30'h30;
        sb.push_back('{1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF});
        D_REQ = 1'b1;
        wait_gnt();
        D_REQ = 1'b0;
        for (int k = 0; k < 3; k++) begin
            D_ADDR = 30'($urandom);
            D_WDATA = $urandom;
            D_RW = 1'b1;
            tick();
            check("hold_maddr", {2'b0, M_ADDR}, 32'h30);
            check("hold_mrw", {31'd0, M_RW}, 32'd0);
        end
        wait_valid(n);
        check("to_cycles", n + 3, 32'd16);
        check("to_mreq", {31'd0, M_REQ}, 32'd0);
        tick();

        // Reset in the middle of a data access
        D_RW = 1'b0;
        D_ADDR = 30'h60;
        sb.push_back('{1'b1, 1'b0, 1'b0, mem_data(30'h60)});
        D_REQ = 1'b1;
        wait_gnt();
        D_REQ = 1'b0;
        tick();
        RSTN = 1'b0;
        tick();
        sb.delete();
        exp_d = '0;
        exp_i = '0;
        check("mr_mreq", {31'd0, M_REQ}, 32'd0);
        check("mr_valid", {30'd0, I_VALID, D_VALID}, 32'd0);
        check("mr_maddr", {2'b0, M_ADDR}, 32'd0);
        check("mr_drdata", D_RDATA, 32'd0);
        check("mr_err", {31'd0, ERR}, 32'd0);
        RSTN = 1'b1;
        force_ack = 1'b1;
        tick();
        force_ack = 1'b0;
        tick();
        tick();
        check("mr_late_ack", {30'd0, I_VALID, D_VALID}, 32'd0);

        // Normal traffic after reset
        mem_lat = 1;
        D_ADDR = 30'h70;
        sb.push_back('{1'b1, 1'b0, 1'b0, mem_data(30'h70)});
        D_REQ = 1'b1;
        wait_gnt();
        D_REQ = 1'b0;
        wait_valid(n);
        tick();
        tick();
        check("sb_empty", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
